// File: rtl/decode_stage_pipe_if.sv
// IF/ID-side inputs and ID/EX-side outputs of the decode stage, bundled as one port.
// master drives the instruction/WB/control side, slave is the decode stage itself.
interface decode_stage_pipe_if #(
  parameter int DATA_W = 32,
  parameter int AW     = 5,
  parameter int CTRL_W = 12
);
  logic              i_valid;
  logic [31:0]       i_instruction;
  logic [DATA_W-1:0] i_pc;
  logic [CTRL_W-1:0] i_ctrl;
  logic              i_memread;
  logic              i_regwrite;
  logic              i_wb_we;
  logic [AW-1:0]     i_wb_addr;
  logic [DATA_W-1:0] i_wb_data;
  logic              i_flush;
  logic              i_stop;
  logic [AW-1:0]     i_dbg_addr;

  logic [DATA_W-1:0] o_dbg_data;
  logic              o_pc_write;
  logic              o_ifid_write;
  logic              o_stall;
  logic              o_ex_valid;
  logic              o_ex_memread;
  logic              o_ex_regwrite;
  logic [CTRL_W-1:0] o_ex_ctrl;
  logic [DATA_W-1:0] o_ex_pc;
  logic [DATA_W-1:0] o_ex_rs_data;
  logic [DATA_W-1:0] o_ex_rt_data;
  logic [DATA_W-1:0] o_ex_imm;
  logic [DATA_W-1:0] o_ex_jtarget;
  logic [AW-1:0]     o_ex_rs;
  logic [AW-1:0]     o_ex_rt;
  logic [AW-1:0]     o_ex_rd;
  logic [5:0]        o_ex_op;
  logic [4:0]        o_ex_shamt;

  modport master (
    output i_valid, i_instruction, i_pc, i_ctrl, i_memread, i_regwrite,
           i_wb_we, i_wb_addr, i_wb_data, i_flush, i_stop, i_dbg_addr,
    input  o_dbg_data, o_pc_write, o_ifid_write, o_stall,
           o_ex_valid, o_ex_memread, o_ex_regwrite, o_ex_ctrl, o_ex_pc,
           o_ex_rs_data, o_ex_rt_data, o_ex_imm, o_ex_jtarget,
           o_ex_rs, o_ex_rt, o_ex_rd, o_ex_op, o_ex_shamt
  );

  modport slave (
    input  i_valid, i_instruction, i_pc, i_ctrl, i_memread, i_regwrite,
           i_wb_we, i_wb_addr, i_wb_data, i_flush, i_stop, i_dbg_addr,
    output o_dbg_data, o_pc_write, o_ifid_write, o_stall,
           o_ex_valid, o_ex_memread, o_ex_regwrite, o_ex_ctrl, o_ex_pc,
           o_ex_rs_data, o_ex_rt_data, o_ex_imm, o_ex_jtarget,
           o_ex_rs, o_ex_rt, o_ex_rd, o_ex_op, o_ex_shamt
  );
endinterface

// File: rtl/decode_stage_pipe.sv
// ID stage: register file with WB bypass, load-use stall FSM and the ID/EX pipeline register.
//   state | meaning
//   RUN   | normal issue; a load-use hazard inserts the first bubble here
//   STALL | further bubbles while cnt counts down to 0
//   HALT  | i_stop frozen; pre-halt state and cnt kept in sav_state/sav_cnt
module decode_stage_pipe #(
  parameter int DATA_W     = 32,
  parameter int NREG       = 32,
  parameter int AW         = 5,
  parameter int CTRL_W     = 12,
  parameter int LOAD_STALL = 1,
  parameter int BYPASS     = 1
) (
  input logic              clk,
  input logic              i_reset_n,
  decode_stage_pipe_if.slave bus
);

  typedef enum logic [1:0] {RUN, STALL, HALT} state_t;

  localparam logic [1:0] STALL_INIT = 2'(LOAD_STALL - 1);

  state_t            state, state_nx, sav_state, sav_state_nx, eff_state;
  logic [1:0]        cnt, cnt_nx, sav_cnt, sav_cnt_nx, eff_cnt;
  logic              bubble, stall_int, haz;

  logic [DATA_W-1:0] rf [NREG];
  logic [5:0]        op;
  logic [AW-1:0]     rs, rt, rd;
  logic [4:0]        shamt;
  logic [DATA_W-1:0] rs_data, rt_data, imm, jtarget;
  logic              byp_rs, byp_rt;

  logic              ex_valid, ex_memread, ex_regwrite;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [DATA_W-1:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm, ex_jtarget;
  logic [AW-1:0]     ex_rs, ex_rt, ex_rd;
  logic [5:0]        ex_op;
  logic [4:0]        ex_shamt;

  assign op      = bus.i_instruction[31:26];
  assign rs      = bus.i_instruction[21 +: AW];
  assign rt      = bus.i_instruction[16 +: AW];
  assign rd      = bus.i_instruction[11 +: AW];
  assign shamt   = bus.i_instruction[10:6];
  assign imm     = DATA_W'($signed(bus.i_instruction[15:0]));
  assign jtarget = DATA_W'(bus.i_instruction[25:0]);

  // Register 0 is never written, so only the bypass path needs the r0 guard.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (bus.i_wb_we && bus.i_wb_addr != '0) begin
      rf[bus.i_wb_addr] <= bus.i_wb_data;
    end
  end

  assign byp_rs  = (BYPASS != 0) && bus.i_wb_we && (bus.i_wb_addr == rs);
  assign byp_rt  = (BYPASS != 0) && bus.i_wb_we && (bus.i_wb_addr == rt);
  assign rs_data = (rs == '0) ? '0 : (byp_rs ? bus.i_wb_data : rf[rs]);
  assign rt_data = (rt == '0) ? '0 : (byp_rt ? bus.i_wb_data : rf[rt]);
  assign bus.o_dbg_data = rf[bus.i_dbg_addr];

  assign haz = bus.i_valid & ex_valid & ex_memread & (ex_rt != '0) &
               ((ex_rt == rs) | (ex_rt == rt));

  // Leaving HALT, the restored state already acts in the release cycle.
  assign eff_state = (state == HALT && !bus.i_stop) ? sav_state : state;
  assign eff_cnt   = (state == HALT && !bus.i_stop) ? sav_cnt   : cnt;

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= RUN;
      cnt       <= 2'd0;
      sav_state <= RUN;
      sav_cnt   <= 2'd0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      sav_state <= sav_state_nx;
      sav_cnt   <= sav_cnt_nx;
    end
  end

  always_comb begin
    state_nx     = eff_state;
    cnt_nx       = eff_cnt;
    sav_state_nx = sav_state;
    sav_cnt_nx   = sav_cnt;
    bubble       = 1'b0;
    stall_int    = 1'b0;
    if (bus.i_stop) begin
      state_nx = HALT;
      cnt_nx   = cnt;
      if (state != HALT) begin
        sav_state_nx = state;
        sav_cnt_nx   = cnt;
      end
    end else if (bus.i_flush) begin
      bubble   = 1'b1;
      state_nx = RUN;
      cnt_nx   = 2'd0;
    end else begin
      unique case (eff_state)
        RUN: begin
          if (haz) begin
            bubble    = 1'b1;
            stall_int = 1'b1;
            cnt_nx    = STALL_INIT;
            state_nx  = (STALL_INIT != 2'd0) ? STALL : RUN;
          end
        end
        STALL: begin
          bubble    = 1'b1;
          stall_int = 1'b1;
          cnt_nx    = (eff_cnt == 2'd0) ? 2'd0 : eff_cnt - 2'd1;
          state_nx  = (eff_cnt <= 2'd1) ? RUN : STALL;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_pc_write   = !i_reset_n | !(bus.i_stop | stall_int) | bus.i_flush;
  assign bus.o_ifid_write = bus.o_pc_write;
  assign bus.o_stall      = i_reset_n & stall_int;

  // Bubbles clear only the control bits; data fields keep their last values.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ex_valid    <= 1'b0;
      ex_memread  <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_ctrl     <= '0;
      ex_pc       <= '0;
      ex_rs_data  <= '0;
      ex_rt_data  <= '0;
      ex_imm      <= '0;
      ex_jtarget  <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_rd       <= '0;
      ex_op       <= '0;
      ex_shamt    <= '0;
    end else if (!bus.i_stop) begin
      if (bubble || !bus.i_valid) begin
        ex_valid    <= 1'b0;
        ex_memread  <= 1'b0;
        ex_regwrite <= 1'b0;
        ex_ctrl     <= '0;
      end else begin
        ex_valid    <= 1'b1;
        ex_memread  <= bus.i_memread;
        ex_regwrite <= bus.i_regwrite;
        ex_ctrl     <= bus.i_ctrl;
        ex_pc       <= bus.i_pc;
        ex_rs_data  <= rs_data;
        ex_rt_data  <= rt_data;
        ex_imm      <= imm;
        ex_jtarget  <= jtarget;
        ex_rs       <= rs;
        ex_rt       <= rt;
        ex_rd       <= rd;
        ex_op       <= op;
        ex_shamt    <= shamt;
      end
    end
  end

  assign bus.o_ex_valid    = ex_valid;
  assign bus.o_ex_memread  = ex_memread;
  assign bus.o_ex_regwrite = ex_regwrite;
  assign bus.o_ex_ctrl     = ex_ctrl;
  assign bus.o_ex_pc       = ex_pc;
  assign bus.o_ex_rs_data  = ex_rs_data;
  assign bus.o_ex_rt_data  = ex_rt_data;
  assign bus.o_ex_imm      = ex_imm;
  assign bus.o_ex_jtarget  = ex_jtarget;
  assign bus.o_ex_rs       = ex_rs;
  assign bus.o_ex_rt       = ex_rt;
  assign bus.o_ex_rd       = ex_rd;
  assign bus.o_ex_op       = ex_op;
  assign bus.o_ex_shamt    = ex_shamt;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe: dut_a has BYPASS=1/LOAD_STALL=1, dut_b has BYPASS=0/LOAD_STALL=3.
// Expected ID/EX contents are queued when an instruction is driven and compared after the edge.
module tb_decode_stage_pipe;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 12;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [11:0] ctrl;
    logic        memread;
    logic        regwrite;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flush;
    logic        stop;
    logic [4:0]  dbg_addr;
  } stim_t;

  typedef struct packed {
    logic        valid;
    logic        memread;
    logic        regwrite;
    logic [11:0] ctrl;
    logic [31:0] pc;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [31:0] jtarget;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  op;
    logic [4:0]  shamt;
  } ex_t;

  logic        clk = 1'b0;
  logic        rst_n;
  stim_t       st [2];
  ex_t         ob [2];
  logic [2:0]  hsk [2];
  logic [31:0] dbg [2];
  logic [31:0] rf_m [2][32];
  ex_t         cur [2];
  ex_t         sb [$];
  ex_t         e;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  decode_stage_pipe_if #(.DATA_W(DW), .AW(AW), .CTRL_W(CW)) bus_a ();
  decode_stage_pipe_if #(.DATA_W(DW), .AW(AW), .CTRL_W(CW)) bus_b ();

  decode_stage_pipe #(.DATA_W(DW), .NREG(32), .AW(AW), .CTRL_W(CW), .LOAD_STALL(1), .BYPASS(1))
    dut_a (.clk(clk), .i_reset_n(rst_n), .bus(bus_a));
  decode_stage_pipe #(.DATA_W(DW), .NREG(32), .AW(AW), .CTRL_W(CW), .LOAD_STALL(3), .BYPASS(0))
    dut_b (.clk(clk), .i_reset_n(rst_n), .bus(bus_b));

  assign bus_a.i_valid = st[0].valid;       assign bus_b.i_valid = st[1].valid;
  assign bus_a.i_instruction = st[0].instr; assign bus_b.i_instruction = st[1].instr;
  assign bus_a.i_pc = st[0].pc;             assign bus_b.i_pc = st[1].pc;
  assign bus_a.i_ctrl = st[0].ctrl;         assign bus_b.i_ctrl = st[1].ctrl;
  assign bus_a.i_memread = st[0].memread;   assign bus_b.i_memread = st[1].memread;
  assign bus_a.i_regwrite = st[0].regwrite; assign bus_b.i_regwrite = st[1].regwrite;
  assign bus_a.i_wb_we = st[0].wb_we;       assign bus_b.i_wb_we = st[1].wb_we;
  assign bus_a.i_wb_addr = st[0].wb_addr;   assign bus_b.i_wb_addr = st[1].wb_addr;
  assign bus_a.i_wb_data = st[0].wb_data;   assign bus_b.i_wb_data = st[1].wb_data;
  assign bus_a.i_flush = st[0].flush;       assign bus_b.i_flush = st[1].flush;
  assign bus_a.i_stop = st[0].stop;         assign bus_b.i_stop = st[1].stop;
  assign bus_a.i_dbg_addr = st[0].dbg_addr; assign bus_b.i_dbg_addr = st[1].dbg_addr;

  assign ob[0] = {bus_a.o_ex_valid, bus_a.o_ex_memread, bus_a.o_ex_regwrite, bus_a.o_ex_ctrl,
                  bus_a.o_ex_pc, bus_a.o_ex_rs_data, bus_a.o_ex_rt_data, bus_a.o_ex_imm,
                  bus_a.o_ex_jtarget, bus_a.o_ex_rs, bus_a.o_ex_rt, bus_a.o_ex_rd,
                  bus_a.o_ex_op, bus_a.o_ex_shamt};
  assign ob[1] = {bus_b.o_ex_valid, bus_b.o_ex_memread, bus_b.o_ex_regwrite, bus_b.o_ex_ctrl,
                  bus_b.o_ex_pc, bus_b.o_ex_rs_data, bus_b.o_ex_rt_data, bus_b.o_ex_imm,
                  bus_b.o_ex_jtarget, bus_b.o_ex_rs, bus_b.o_ex_rt, bus_b.o_ex_rd,
                  bus_b.o_ex_op, bus_b.o_ex_shamt};
  assign hsk[0] = {bus_a.o_pc_write, bus_a.o_ifid_write, bus_a.o_stall};
  assign hsk[1] = {bus_b.o_pc_write, bus_b.o_ifid_write, bus_b.o_stall};
  assign dbg[0] = bus_a.o_dbg_data;
  assign dbg[1] = bus_b.o_dbg_data;

  function automatic logic [31:0] r_ins(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'd2, 6'h20};
  endfunction

  function automatic logic [31:0] i_ins(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                        logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // dut index 0 forwards same-cycle WB data, index 1 does not
  function automatic logic [31:0] rd_m(int d, logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (d == 0 && st[d].wb_we && st[d].wb_addr == a) return st[d].wb_data;
    return rf_m[d][a];
  endfunction

  function automatic ex_t exp_issue(int d);
    ex_t x;
    logic [31:0] ins;
    ins        = st[d].instr;
    x.valid    = 1'b1;
    x.memread  = st[d].memread;
    x.regwrite = st[d].regwrite;
    x.ctrl     = st[d].ctrl;
    x.pc       = st[d].pc;
    x.rs_data  = rd_m(d, ins[25:21]);
    x.rt_data  = rd_m(d, ins[20:16]);
    x.imm      = {{16{ins[15]}}, ins[15:0]};
    x.jtarget  = {6'd0, ins[25:0]};
    x.rs       = ins[25:21];
    x.rt       = ins[20:16];
    x.rd       = ins[15:11];
    x.op       = ins[31:26];
    x.shamt    = ins[10:6];
    return x;
  endfunction

  function automatic ex_t exp_bubble(int d);
    ex_t x;
    x          = cur[d];
    x.valid    = 1'b0;
    x.memread  = 1'b0;
    x.regwrite = 1'b0;
    x.ctrl     = 12'd0;
    return x;
  endfunction

  task automatic set_ins(int d, logic [31:0] ins, logic [31:0] pc, logic [11:0] ctrl,
                         logic memread, logic regwrite);
    st[d].valid    = 1'b1;
    st[d].instr    = ins;
    st[d].pc       = pc;
    st[d].ctrl     = ctrl;
    st[d].memread  = memread;
    st[d].regwrite = regwrite;
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++)
      if (st[k].wb_we && st[k].wb_addr != 5'd0) rf_m[k][st[k].wb_addr] = st[k].wb_data;
    #1;
  endtask

  task automatic clear_model();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 32; r++) rf_m[k][r] = 32'd0;
      cur[k] = '0;
    end
    sb.delete();
  endtask

  task automatic test_reset();
    st[0] = '0; st[1] = '0;
    rst_n = 1'b0;
    clear_model();
    #7;
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (ob[d] !== '0) begin n_fail++; $display("FAIL reset_ex[%0d]: got %h want 0", d, ob[d]); end
      n_chk++;
      if (hsk[d] !== 3'b110) begin n_fail++; $display("FAIL reset_hsk[%0d]: got %b want 110", d, hsk[d]); end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_regfile_read();
    st[0] = '0;
    st[0].wb_we = 1'b1; st[0].wb_addr = 5'd5; st[0].wb_data = 32'h1234;
    sb.push_back(exp_bubble(0)); tick();
    e = sb.pop_front(); n_chk++;
    if (ob[0] !== e) begin n_fail++; $display("FAIL wb_only: got %h want %h", ob[0], e); end
    cur[0] = e;
    st[0] = '0;
    set_ins(0, r_ins(5'd5, 5'd0, 5'd3), 32'h100, 12'hABC, 1'b0, 1'b1);
    st[0].dbg_addr = 5'd5;
    #1;
    n_chk++;
    if (dbg[0] !== 32'h1234) begin n_fail++; $display("FAIL dbg_r5: got %h want 00001234", dbg[0]); end
    n_chk++;
    if (hsk[0] !== 3'b110) begin n_fail++; $display("FAIL add_hsk: got %b want 110", hsk[0]); end
    sb.push_back(exp_issue(0)); tick();
    e = sb.pop_front(); n_chk++;
    if (ob[0] !== e) begin n_fail++; $display("FAIL add_issue: got %h want %h", ob[0], e); end
    cur[0] = e;
    st[0] = '0;
  endtask

  task automatic test_bypass(int d);
    st[d] = '0;
    st[d].wb_we = 1'b1; st[d].wb_addr = 5'd7; st[d].wb_data = 32'h1111;
    sb.push_back(exp_bubble(d)); tick();
    e = sb.pop_front(); n_chk++;
    if (ob[d] !== e) begin n_fail++; $display("FAIL byp_pre[%0d]: got %h want %h", d, ob[d], e); end
    cur[d] = e;
    st[d].wb_data = 32'hCAFE;
    st[d].dbg_addr = 5'd7;
    set_ins(d, r_ins(5'd7, 5'd7, 5'd9), 32'h200 + 32'(d), 12'h5A5, 1'b0, 1'b1);
    #1;
    n_chk++;
    if (dbg[d] !== 32'h1111) begin n_fail++; $display("FAIL dbg_unbyp[%0d]: got %h want 00001111", d, dbg[d]); end
    sb.push_back(exp_issue(d)); tick();
    e = sb.pop_front(); n_chk++;
    if (ob[d] !== e) begin n_fail++; $display("FAIL bypass[%0d]: got %h want %h", d, ob[d], e); end
    cur[d] = e;
    n_chk++;
    if (dbg[d] !== 32'hCAFE) begin n_fail++; $display("FAIL dbg_after_wb[%0d]: got %h want 0000cafe", d, dbg[d]); end
    st[d] = '0;
  endtask

  task automatic issue_load(int d, logic [31:0] pc);
    st[d] = '0;
    set_ins(d, i_ins(6'h23, 5'd1, 5'd4, 16'hFFFC), pc, 12'h011, 1'b1, 1'b1);
    sb.push_back(exp_issue(d)); tick();
    e = sb.pop_front(); n_chk++;
    if (ob[d] !== e) begin n_fail++; $display("FAIL lw_issue[%0d]: got %h want %h", d, ob[d], e); end
    cur[d] = e;
  endtask

  task automatic test_load_use(int d);
    int ls;
    ls = (d == 0) ? 1 : 3;
    issue_load(d, 32'h300);
    set_ins(d, r_ins(5'd4, 5'd2, 5'd6), 32'h304, 12'h022, 1'b0, 1'b1);
    for (int k = 0; k < ls; k++) begin
      #1;
      n_chk++;
      if (hsk[d] !== 3'b001) begin n_fail++; $display("FAIL lu_hsk[%0d.%0d]: got %b want 001", d, k, hsk[d]); end
      sb.push_back(exp_bubble(d)); tick();
      e = sb.pop_front(); n_chk++;
      if (ob[d] !== e) begin n_fail++; $display("FAIL lu_bubble[%0d.%0d]: got %h want %h", d, k, ob[d], e); end
      cur[d] = e;
    end
    #1;
    n_chk++;
    if (hsk[d] !== 3'b110) begin n_fail++; $display("FAIL lu_release[%0d]: got %b want 110", d, hsk[d]); end
    sb.push_back(exp_issue(d)); tick();
    e = sb.pop_front(); n_chk++;
    if (ob[d] !== e) begin n_fail++; $display("FAIL lu_issue[%0d]: got %h want %h", d, ob[d], e); end
    cur[d] = e;
    st[d] = '0;
  endtask

  task automatic test_flush_in_stall();
    issue_load(1, 32'h380);
    set_ins(1, r_ins(5'd4, 5'd2, 5'd6), 32'h384, 12'h022, 1'b0, 1'b1);
    #1;
    n_chk++;
    if (hsk[1] !== 3'b001) begin n_fail++; $display("FAIL fl_stall1: got %b want 001", hsk[1]); end
    sb.push_back(exp_bubble(1)); tick();
    e = sb.pop_front(); n_chk++;
    if (ob[1] !== e) begin n_fail++; $display("FAIL fl_bubble1: got %h want %h", ob[1], e); end
    cur[1] = e;
    st[1].flush = 1'b1;
    #1;
    n_chk++;
    if (hsk[1] !== 3'b110) begin n_fail++; $display("FAIL fl_hsk: got %b want 110", hsk[1]); end
    sb.push_back(exp_bubble(1)); tick();
    e = sb.pop_front(); n_chk++;
    if (ob[1] !== e) begin n_fail++; $display("FAIL fl_bubble: got %h want %h", ob[1], e); end
    cur[1] = e;
    st[1].flush = 1'b0;
    for (int k = 0; k < 2; k++) begin
      set_ins(1, r_ins((k == 0) ? 5'd4 : 5'd1, 5'd2, 5'd8 + 5'(k)), 32'h400 + 32'(4 * k),
              12'h033, 1'b0, 1'b1);
      #1;
      n_chk++;
      if (hsk[1] !== 3'b110) begin n_fail++; $display("FAIL fl_after_hsk[%0d]: got %b want 110", k, hsk[1]); end
      sb.push_back(exp_issue(1)); tick();
      e = sb.pop_front(); n_chk++;
      if (ob[1] !== e) begin n_fail++; $display("FAIL fl_after_issue[%0d]: got %h want %h", k, ob[1], e); end
      cur[1] = e;
    end
    st[1] = '0;
  endtask

  task automatic test_stop_in_stall();
    issue_load(1, 32'h480);
    set_ins(1, r_ins(5'd2, 5'd4, 5'd6), 32'h484, 12'h044, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      #1;
      n_chk++;
      if (hsk[1] !== 3'b001) begin n_fail++; $display("FAIL st_pre_hsk[%0d]: got %b want 001", k, hsk[1]); end
      sb.push_back(exp_bubble(1)); tick();
      e = sb.pop_front(); n_chk++;
      if (ob[1] !== e) begin n_fail++; $display("FAIL st_pre_bubble[%0d]: got %h want %h", k, ob[1], e); end
      cur[1] = e;
    end
    st[1].stop = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_chk++;
      if (hsk[1] !== 3'b000) begin n_fail++; $display("FAIL st_hold_hsk[%0d]: got %b want 000", k, hsk[1]); end
      sb.push_back(cur[1]); tick();
      e = sb.pop_front(); n_chk++;
      if (ob[1] !== e) begin n_fail++; $display("FAIL st_freeze[%0d]: got %h want %h", k, ob[1], e); end
    end
    st[1].stop = 1'b0;
    #1;
    n_chk++;
    if (hsk[1] !== 3'b001) begin n_fail++; $display("FAIL st_post_hsk: got %b want 001", hsk[1]); end
    sb.push_back(exp_bubble(1)); tick();
    e = sb.pop_front(); n_chk++;
    if (ob[1] !== e) begin n_fail++; $display("FAIL st_post_bubble: got %h want %h", ob[1], e); end
    cur[1] = e;
    #1;
    n_chk++;
    if (hsk[1] !== 3'b110) begin n_fail++; $display("FAIL st_issue_hsk: got %b want 110", hsk[1]); end
    sb.push_back(exp_issue(1)); tick();
    e = sb.pop_front(); n_chk++;
    if (ob[1] !== e) begin n_fail++; $display("FAIL st_issue: got %h want %h", ob[1], e); end
    cur[1] = e;
    st[1] = '0;
  endtask

  task automatic test_r0();
    st[0] = '0;
    st[0].wb_we = 1'b1; st[0].wb_addr = 5'd0; st[0].wb_data = 32'hFFFF;
    set_ins(0, r_ins(5'd0, 5'd0, 5'd11), 32'h500, 12'h0F0, 1'b0, 1'b1);
    #1;
    n_chk++;
    if (dbg[0] !== 32'd0) begin n_fail++; $display("FAIL r0_dbg: got %h want 0", dbg[0]); end
    sb.push_back(exp_issue(0)); tick();
    e = sb.pop_front(); n_chk++;
    if (ob[0] !== e) begin n_fail++; $display("FAIL r0_same_cycle: got %h want %h", ob[0], e); end
    cur[0] = e;
    st[0].wb_we = 1'b0;
    set_ins(0, r_ins(5'd0, 5'd5, 5'd12), 32'h504, 12'h0F1, 1'b0, 1'b1);
    sb.push_back(exp_issue(0)); tick();
    e = sb.pop_front(); n_chk++;
    if (ob[0] !== e) begin n_fail++; $display("FAIL r0_after: got %h want %h", ob[0], e); end
    cur[0] = e;
    n_chk++;
    if (dbg[0] !== 32'd0) begin n_fail++; $display("FAIL r0_dbg_after: got %h want 0", dbg[0]); end
    st[0] = '0;
  endtask

  task automatic test_async_reset();
    st[0] = '0;
    set_ins(0, r_ins(5'd5, 5'd7, 5'd13), 32'h600, 12'hFFF, 1'b1, 1'b1);
    sb.push_back(exp_issue(0)); tick();
    e = sb.pop_front(); n_chk++;
    if (ob[0] !== e) begin n_fail++; $display("FAIL ar_issue: got %h want %h", ob[0], e); end
    cur[0] = e;
    st[0] = '0;
    st[0].dbg_addr = 5'd5;
    issue_load(1, 32'h680);
    set_ins(1, r_ins(5'd4, 5'd4, 5'd6), 32'h684, 12'h055, 1'b0, 1'b1);
    sb.push_back(exp_bubble(1)); tick();
    e = sb.pop_front(); n_chk++;
    if (ob[1] !== e) begin n_fail++; $display("FAIL ar_bubble: got %h want %h", ob[1], e); end
    cur[1] = e;
    #2;
    rst_n = 1'b0;
    #1;
    clear_model();
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (ob[d] !== '0) begin n_fail++; $display("FAIL ar_clear[%0d]: got %h want 0", d, ob[d]); end
      n_chk++;
      if (hsk[d] !== 3'b110) begin n_fail++; $display("FAIL ar_hsk[%0d]: got %b want 110", d, hsk[d]); end
    end
    n_chk++;
    if (dbg[0] !== 32'd0) begin n_fail++; $display("FAIL ar_rf_clear: got %h want 0", dbg[0]); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_chk++;
    if (hsk[1] !== 3'b110) begin n_fail++; $display("FAIL ar_no_stall: got %b want 110", hsk[1]); end
    sb.push_back(exp_issue(1)); tick();
    e = sb.pop_front(); n_chk++;
    if (ob[1] !== e) begin n_fail++; $display("FAIL ar_consumer: got %h want %h", ob[1], e); end
    cur[1] = e;
    st[1] = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_regfile_read();
    test_bypass(0);
    test_bypass(1);
    test_load_use(0);
    test_load_use(1);
    test_flush_in_stall();
    test_stop_in_stall();
    test_r0();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
